// File: rtl/collector_pkg.sv
// Shared state type and counter sizing for the nibble result collector.
// COLLECTOR_CHECKSUM_EN appends one XOR checksum byte to every frame.
package collector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } coll_state_t;

   localparam int BYTE_W = 8;

`ifdef COLLECTOR_CHECKSUM_EN
   localparam int CHK_BYTES = 1;
`else
   localparam int CHK_BYTES = 0;
`endif

   // A counter for a single value still needs one bit to exist.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int slice_cnt_w(input int n, input int nw);
      return cnt_w(n / nw);
   endfunction

   function automatic int byte_idx_w(input int n);
      return cnt_w(n / BYTE_W + CHK_BYTES);
   endfunction

endpackage

// File: rtl/collector_byte_sel.sv
// Combinational byte selector over the captured result word.
// With COLLECTOR_CHECKSUM_EN, index N/8 selects the XOR of all data bytes.
module collector_byte_sel
   import collector_pkg::*;
#(
   parameter int N     = 64,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]      word_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [BYTE_W-1:0] byte_o
);

   localparam int NDB = N / BYTE_W;

`ifdef COLLECTOR_CHECKSUM_EN
   logic [BYTE_W-1:0] chk;

   always_comb begin
      chk = '0;
      for (int b = 0; b < NDB; b++) chk = chk ^ word_i[b*BYTE_W +: BYTE_W];
   end
`endif

   always_comb begin
      byte_o = '0;
      for (int b = 0; b < NDB; b++) begin
         if (idx_i == IDX_W'(b)) byte_o = word_i[b*BYTE_W +: BYTE_W];
      end
`ifdef COLLECTOR_CHECKSUM_EN
      if (idx_i == IDX_W'(NDB)) byte_o = chk;
`endif
   end

endmodule

// File: rtl/nibble_result_collector.sv
// Collects N_width-bit result slices into an N-bit word, then replays it LSB byte first
// over valid/ready. Define COLLECTOR_CHECKSUM_EN for a trailing XOR checksum byte.
module nibble_result_collector
   import collector_pkg::*;
#(
   parameter int N       = 64,
   parameter int N_width = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [N_width-1:0] in_data,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [7:0]         out_data,
   output logic               out_last,
   output logic               busy,
   output logic               overflow,
   output logic [7:0]         word_count
);

   localparam int SLICES = N / N_width;
   localparam int NB     = N / BYTE_W + CHK_BYTES;
   localparam int SW     = slice_cnt_w(N, N_width);
   localparam int BW     = byte_idx_w(N);
   localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES - 1);
   localparam logic [BW-1:0] BYTE_LAST  = BW'(NB - 1);

   coll_state_t       state_q, state_d;
   logic [SW-1:0]     slice_cnt_q, slice_cnt_d;
   logic [BW-1:0]     byte_idx_q, byte_idx_d;
   logic [N-1:0]      word_q, word_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        word_count_q, word_count_d;
   logic [BYTE_W-1:0] sel_byte;

   // Select from next-state values so the first byte is registered with the last slice.
   collector_byte_sel #(
      .N     (N),
      .IDX_W (BW)
   ) u_byte_sel (
      .word_i (word_d),
      .idx_i  (byte_idx_d),
      .byte_o (sel_byte)
   );

   always_comb begin
      state_d      = state_q;
      slice_cnt_d  = slice_cnt_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      overflow_d   = overflow_q;
      word_count_d = word_count_q;
      out_data_d   = out_data_q;

      unique case (state_q)
         IDLE, COLLECT: begin
            if (in_valid) begin
               for (int s = 0; s < SLICES; s++) begin
                  if (slice_cnt_q == SW'(s)) word_d[s*N_width +: N_width] = in_data;
               end
               if (slice_cnt_q == SLICE_LAST) begin
                  slice_cnt_d = '0;
                  byte_idx_d  = '0;
                  state_d     = DRAIN;
               end else begin
                  slice_cnt_d = slice_cnt_q + SW'(1);
                  state_d     = COLLECT;
               end
            end
         end
         DRAIN: begin
            if (in_valid) overflow_d = 1'b1;
            if (out_valid_q && out_ready) begin
               if (byte_idx_q == BYTE_LAST) begin
                  byte_idx_d   = '0;
                  word_count_d = word_count_q + 8'd1;
                  state_d      = IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DRAIN);
      out_last_d  = (state_d == DRAIN) && (byte_idx_d == BYTE_LAST);
      if (state_d == DRAIN) out_data_d = sel_byte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         slice_cnt_q  <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         overflow_q   <= 1'b0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         slice_cnt_q  <= slice_cnt_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         overflow_q   <= overflow_d;
         word_count_q <= word_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign busy       = (state_q != IDLE);
   assign overflow   = overflow_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_nibble_result_collector.sv
// Scoreboard bench for nibble_result_collector (N=64, N_width=4); expected bytes are
// queued as frames are issued and popped by a monitor on every accepted byte.
module tb_nibble_result_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       out_ready = 1'b1;
   logic       out_valid, out_last, busy, overflow;
   logic [7:0] out_data, word_count;

   int total = 0;
   int bad = 0;
   logic [8:0] expq[$];
   logic [8:0] mon_e;

`ifdef COLLECTOR_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam logic [63:0] W_SEQ = 64'hFEDCBA9876543210;

   always #5 clk = ~clk;

   nibble_result_collector #(
      .N       (64),
      .N_width (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .overflow   (overflow),
      .word_count (word_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted byte must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h want none", out_data);
         end else begin
            mon_e = expq.pop_front();
            chk("byte_last_data", {23'd0, out_last, out_data}, {23'd0, mon_e});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [63:0] w, input logic [7:0] csum);
      for (int b = 0; b < 8; b++) expq.push_back({(!CHK && b == 7), w[b*8 +: 8]});
      if (CHK) expq.push_back({1'b1, csum});
   endtask

   task automatic send_word(input logic [63:0] w, input logic [7:0] csum, input bit gap);
      push_frame(w, csum);
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = w[i*4 +: 4];
         step();
         if (gap && i < 15) begin
            in_valid = 1'b0;
            step();
         end
      end
      in_valid = 1'b0;
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      chk("first_byte", {24'd0, out_data}, {24'd0, w[7:0]});
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_word_count", {24'd0, word_count}, 32'd0);
      rst = 1'b1;
      step();

      // Counting nibbles: bytes 10,32,..,FE; checksum of these is 00
      send_word(W_SEQ, 8'h00, 1'b0);
      wait_idle("t1");
      chk("t1_word_count", {24'd0, word_count}, 32'd1);

      // Single non-zero slice: bytes 05,00x7, checksum 05
      send_word(64'h0000_0000_0000_0005, 8'h05, 1'b0);
      wait_idle("t2");
      chk("t2_word_count", {24'd0, word_count}, 32'd2);

      // Back-pressure on byte 2 (0x54)
      send_word(W_SEQ, 8'h00, 1'b0);
      step();
      step();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("t3_hold_data", {24'd0, out_data}, 32'h54);
      end
      out_ready = 1'b1;
      wait_idle("t3");
      chk("t3_word_count", {24'd0, word_count}, 32'd3);

      // Gapped slice delivery
      send_word(W_SEQ, 8'h00, 1'b1);
      wait_idle("t4");
      chk("t4_word_count", {24'd0, word_count}, 32'd4);

      // Slice arriving during drain of byte 4
      send_word(W_SEQ, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) step();
      chk("t5_byte4", {24'd0, out_data}, 32'h98);
      in_valid = 1'b1;
      in_data  = 4'h3;
      step();
      in_valid = 1'b0;
      chk("t5_overflow_set", {31'd0, overflow}, 32'd1);
      wait_idle("t5");
      chk("t5_overflow_hold", {31'd0, overflow}, 32'd1);
      chk("t5_word_count", {24'd0, word_count}, 32'd5);
      send_word(64'h0123456789ABCDEF, 8'h00, 1'b0);
      wait_idle("t5b");
      chk("t5b_overflow_sticky", {31'd0, overflow}, 32'd1);
      chk("t5b_word_count", {24'd0, word_count}, 32'd6);

      // Asynchronous reset after 7 slices
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i + 9);
         step();
      end
      in_valid = 1'b0;
      chk("t6_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_out_data", {24'd0, out_data}, 32'd0);
      chk("t6_out_last", {31'd0, out_last}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_overflow", {31'd0, overflow}, 32'd0);
      chk("t6_word_count", {24'd0, word_count}, 32'd0);
      step();
      rst = 1'b1;
      step();
      // XOR of A5,0F,3C,96? bytes: 69,96,3C,3C,0F,0F,A5,A5 -> 69^96 = FF
      send_word(64'hA5A5_0F0F_3C3C_9669, 8'hFF, 1'b0);
      wait_idle("t6");
      chk("t6_word_count_after", {24'd0, word_count}, 32'd1);
      chk("t6_overflow_after", {31'd0, overflow}, 32'd0);
      chk("queue_empty", expq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
